// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM word, RAM handshake state, and memory arbiter FSM state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_t;

  localparam int unsigned STARVE_LIMIT_DEF = 4;
  localparam int unsigned TIMEOUT_DEF      = 255;

endpackage

// File: rtl/sat_counter.sv
// Unsigned up-counter that saturates at MAX; synchronous clear and reset to zero.
module sat_counter #(
  parameter int unsigned W   = 4,
  parameter int unsigned MAX = 15
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         at_max
);

  localparam logic [W-1:0] MAXV = W'(MAX);

  assign at_max = (cnt == MAXV);

  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Single-port RAM arbiter between icache fill and dcache fill/writeback.
// Dcache wins by default; a starvation counter forces fetch through, a watchdog aborts hung grants.
module mem_bus_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int unsigned TIMEOUT      = TIMEOUT_DEF
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      bus_err
);

  arb_state_t state, cur;
  logic       dreq, access, rerr, req_gnt, fin;
  logic       go_d, go_i;
  logic       starve_clr, starve_inc, starve_max;
  logic       wd_clr, wd_inc, wd_max;
  logic [3:0] starve_cnt;
  logic [7:0] wd_cnt;
  logic       unused_cnt;

  assign dreq    = dREN | dWEN;
  assign access  = (ramstate == ACCESS);
  assign rerr    = (ramstate == ERROR);
  assign req_gnt = (state == GNT_I) ? iREN : dreq;
  assign fin     = access | rerr | wd_max;

  // Reset masks the grant immediately so no strobe or completion leaks out mid-transaction.
  assign cur = RST ? IDLE : state;

  // A starved icache only blocks the dcache while it is actually still asking.
  assign go_d = dreq && (!starve_max || !iREN);
  assign go_i = !go_d && iREN;

  assign starve_clr = (state == IDLE) && go_i;
  assign starve_inc = (state == IDLE) && go_d && iREN;
  assign wd_clr     = (state == IDLE);
  assign wd_inc     = (state != IDLE) && !access && !rerr;

  sat_counter #(.W(4), .MAX(STARVE_LIMIT)) u_starve (
    .CLK    (CLK),
    .RST    (RST),
    .clr    (starve_clr),
    .inc    (starve_inc),
    .cnt    (starve_cnt),
    .at_max (starve_max)
  );

  sat_counter #(.W(8), .MAX(TIMEOUT - 1)) u_wd (
    .CLK    (CLK),
    .RST    (RST),
    .clr    (wd_clr),
    .inc    (wd_inc),
    .cnt    (wd_cnt),
    .at_max (wd_max)
  );

  // Raw counts are kept for observation only; decisions use the max flags.
  assign unused_cnt = ^{starve_cnt, wd_cnt};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      bus_err <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (go_d) begin
            state <= GNT_D;
          end else if (go_i) begin
            state <= GNT_I;
          end
        end
        GNT_I, GNT_D: begin
          if (access || rerr || !req_gnt || wd_max) begin
            state   <= IDLE;
            bus_err <= !access && (rerr || (req_gnt && wd_max));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign iload = ramload;
  assign dload = ramload;

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = iREN;
    dwait    = dreq;
    case (cur)
      GNT_I: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        iwait   = iREN & ~fin;
      end
      GNT_D: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        dwait    = dreq & ~fin;
      end
      default: ;
    endcase
  end

endmodule
